// File: rtl/cp0_unit_if.sv
// Bundle between the M-stage pipeline logic and coprocessor 0.
// It carries the mtc0/mfc0 port, the victim instruction state, the interrupt lines and the redirect outputs.
interface cp0_unit_if #(
  parameter int HWINT_W = 6
);
  logic               en;
  logic [4:0]         CP0Add;
  logic [31:0]        CP0In;
  logic [31:0]        CP0Out;
  logic [31:0]        VPC;
  logic               BDIn;
  logic [4:0]         ExcCodeIn;
  logic [HWINT_W-1:0] HWInt;
  logic               EXLClr;
  logic [31:0]        EPCOut;
  logic               Req;

  modport master (
    output en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  CP0Out, EPCOut, Req
  );

  modport slave (
    input  en, CP0Add, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output CP0Out, EPCOut, Req
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: holds SR, Cause, EPC and PRId, and samples the hardware interrupt lines.
// It also decides exception/interrupt entry for the M-stage victim instruction.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_0712,
  parameter int          HWINT_W    = 6
) (
  input  logic      clk,
  input  logic      reset,
  cp0_unit_if.slave bus
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [HWINT_W-1:0] sr_im_q, sr_im_d;
  logic               sr_exl_q, sr_exl_d;
  logic               sr_ie_q, sr_ie_d;
  logic               cause_bd_q, cause_bd_d;
  logic [HWINT_W-1:0] cause_ip_q, cause_ip_d;
  logic [4:0]         cause_exc_q, cause_exc_d;
  logic [31:2]        epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [31:0] epc_word;
  logic        unused_vpc_lsbs;

  assign unused_vpc_lsbs = ^bus.VPC[1:0];

  // While reset is held no redirect may be issued, even if the victim carries an exception code.
  always_comb begin
    int_req = (|(bus.HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    exc_req = (bus.ExcCodeIn != 5'd0) & ~sr_exl_q;
    req     = (int_req | exc_req) & ~reset;
  end

  // Entry has priority over eret and mtc0. A delay-slot victim restarts at its branch,
  // so the word index is decremented, which also wraps cleanly for a PC below 4.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = bus.HWInt;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;

    if (req) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = bus.BDIn;
      cause_exc_d = int_req ? 5'd0 : bus.ExcCodeIn;
      epc_d       = bus.VPC[31:2] - {29'd0, bus.BDIn};
    end else begin
      if (bus.EXLClr) begin
        sr_exl_d = 1'b0;
      end
      if (bus.en) begin
        unique case (bus.CP0Add)
          ADDR_SR: begin
            sr_im_d  = bus.CP0In[10 +: HWINT_W];
            sr_exl_d = bus.CP0In[1];
            sr_ie_d  = bus.CP0In[0];
          end
          ADDR_EPC: begin
            epc_d = bus.CP0In[31:2];
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= 5'd0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  // Architectural views of the registers; fields not listed read as zero.
  always_comb begin
    sr_word                    = '0;
    sr_word[10 +: HWINT_W]     = sr_im_q;
    sr_word[1]                 = sr_exl_q;
    sr_word[0]                 = sr_ie_q;
    cause_word                 = '0;
    cause_word[31]             = cause_bd_q;
    cause_word[10 +: HWINT_W]  = cause_ip_q;
    cause_word[6:2]            = cause_exc_q;
    epc_word                   = {epc_q, 2'b00};
  end

  always_comb begin
    unique case (bus.CP0Add)
      ADDR_SR:    bus.CP0Out = sr_word;
      ADDR_CAUSE: bus.CP0Out = cause_word;
      ADDR_EPC:   bus.CP0Out = epc_word;
      ADDR_PRID:  bus.CP0Out = PRID_VALUE;
      default:    bus.CP0Out = 32'd0;
    endcase
  end

  assign bus.EPCOut = epc_word;
  assign bus.Req    = req;

endmodule
